id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: id_valid  input  1; id_muxctrl  input  16; id_memctrl  input  3; id_aluctrl  input  5. These carry the decode-stage instruction valid flag and the controller outputs.
REQ-004 SHALL have ports: id_rd1, id_rd2, id_imm, id_pc  input  32 each. These are the register read data, the extended immediate and the instruction PC.
REQ-005 SHALL have ports: id_rs, id_rt, id_rd, id_shamt  input  5 each. These are the instruction fields.
REQ-006 SHALL have ports: stall  input  1 (external hold, e.g. memory wait) and flush  input  1 (branch/jump squash).
REQ-007 SHALL have registered outputs ex_valid(1), ex_muxctrl(16), ex_memctrl(3), ex_aluctrl(5), ex_rd1(32), ex_rd2(32), ex_imm(32), ex_pc(32), ex_rs(5), ex_rt(5), ex_shamt(5), ex_dest(5).
REQ-008 SHALL have output: hazard_stall  output  1  combinational load-use detect; tells IF/PC to hold.
REQ-009 SHALL have output: bubble_cnt  output  16  registered count of inserted bubbles.

Function
REQ-010 SHALL compute dest_sel = id_muxctrl[0] ? id_rt : id_rd.
REQ-011 SHALL define the bubble as: valid=0, muxctrl=0, memctrl=0, aluctrl=5'b01101, all data/field registers=0.
REQ-012 SHALL drive hazard_stall=1 iff all of the following hold: ex_valid, ex_memctrl[2], ex_dest!=0, id_valid, and (ex_dest==id_rs or (ex_dest==id_rt and id_muxctrl[0]==0)). Otherwise hazard_stall=0.
REQ-013 SHALL update on each rising edge by priority, highest first: reset, then flush, then stall, then hazard_stall, then normal load.
REQ-014 flush=1: SHALL load the bubble, overriding stall and hazard_stall.
REQ-015 stall=1 (flush=0): SHALL hold every output register unchanged.
REQ-016 hazard_stall=1 (flush=0, stall=0): SHALL load the bubble.
REQ-017 Normal load: SHALL capture all id_* inputs (ex_dest = dest_sel) with 1-cycle latency, and ex_valid=id_valid.
REQ-018 id_valid=0 during normal load: SHALL load the bubble regardless of the other id_* values.
REQ-019 bubble_cnt SHALL increment by 1 on each edge where a bubble is loaded due to flush or hazard_stall; it SHALL NOT increment on stall cycles or on id_valid=0 loads.
REQ-020 bubble_cnt SHALL saturate at 16'hFFFF and not wrap.
REQ-021 After a hazard bubble, the dependent instruction SHALL remain on id_* (upstream held), so it loads on the next non-stalled edge, since the hazard then clears.
REQ-022 Simultaneous flush and hazard_stall on one edge SHALL increment bubble_cnt exactly once.

Reset
REQ-023 With reset=1 at a rising edge, all output registers SHALL take bubble values, and bubble_cnt SHALL be 0; this overrides flush and stall.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight instruction within one edge.
REQ-025 hazard_stall SHALL read 0 one edge after reset, because ex_valid=0.

Verification
REQ-026 Normal load: ADD (muxctrl=0, memctrl=001, aluctrl=00010), rd=5, id_rd1=32'h10 -> next cycle: ex_valid=1, ex_dest=5, ex_aluctrl=00010, ex_rd1=32'h10.
REQ-027 Load-use hazard: LW into rt=8 (memctrl=100, muxctrl[0]=1) followed by ADD with rs=8 -> hazard_stall=1 for one cycle, a bubble is loaded, bubble_cnt=1, and ADD loads on the following edge.
REQ-028 Hazard exclusions: LW with dest=0 followed by an ADD with rs=0 -> hazard_stall=0. LW dest=8 followed by ADDI with rt=8, rs=3 -> hazard_stall=0.
REQ-029 Stall hold: stall=1 for 3 cycles while id_* changes -> outputs frozen and bubble_cnt unchanged; stall=1 together with flush=1 -> bubble loaded and bubble_cnt+1.
REQ-030 Saturation: preload 16'hFFFE via 2^16-2 flushes (or force), then 3 further flushes -> bubble_cnt=16'hFFFF.
REQ-031 Reset mid-stream: valid SW in stage, reset=1 for one edge -> ex_valid=0, ex_memctrl=000, ex_aluctrl=01101, bubble_cnt=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for a 5-stage MIPS-style pipeline. It captures the
// decoded instruction from the decode stage, and it detects load-use hazards
// against the instruction currently held in EX. It also counts the bubbles
// that it inserts.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   id_valid          decode-stage instruction valid
//   id_muxctrl[15:0]  controller mux selects (bit 0 = destination is rt)
//   id_memctrl[2:0]   controller memory controls (bit 2 = load)
//   id_aluctrl[4:0]   controller ALU operation
//   id_rd1, id_rd2    register file read data
//   id_imm, id_pc     extended immediate, instruction PC
//   id_rs/rt/rd/shamt instruction fields
//   stall             external hold (e.g. memory wait)
//   flush             branch/jump squash
//   ex_*              registered copies of the above for the EX stage;
//                     ex_dest is the selected destination register
//   hazard_stall      combinational load-use detect; upstream must hold
//   bubble_cnt        saturating count of bubbles inserted by flush/hazard
// -----------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [15:0] id_muxctrl,
    input  logic [2:0]  id_memctrl,
    input  logic [4:0]  id_aluctrl,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [15:0] ex_muxctrl,
    output logic [2:0]  ex_memctrl,
    output logic [4:0]  ex_aluctrl,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_shamt,
    output logic [4:0]  ex_dest,
    output logic        hazard_stall,
    output logic [15:0] bubble_cnt
);

    // ALU code carried by a bubble.
    localparam logic [4:0]  BUBBLE_ALU = 5'b01101;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    logic        ex_valid_reg,   ex_valid_next;
    logic [15:0] ex_muxctrl_reg, ex_muxctrl_next;
    logic [2:0]  ex_memctrl_reg, ex_memctrl_next;
    logic [4:0]  ex_aluctrl_reg, ex_aluctrl_next;
    logic [31:0] ex_rd1_reg,     ex_rd1_next;
    logic [31:0] ex_rd2_reg,     ex_rd2_next;
    logic [31:0] ex_imm_reg,     ex_imm_next;
    logic [31:0] ex_pc_reg,      ex_pc_next;
    logic [4:0]  ex_rs_reg,      ex_rs_next;
    logic [4:0]  ex_rt_reg,      ex_rt_next;
    logic [4:0]  ex_shamt_reg,   ex_shamt_next;
    logic [4:0]  ex_dest_reg,    ex_dest_next;
    logic [15:0] bubble_cnt_reg, bubble_cnt_next;

    logic [4:0]  dest_sel;
    logic        hazard;
    logic        load_bubble;
    logic        load_instr;
    logic        count_bubble;

    assign dest_sel = id_muxctrl[0] ? id_rt : id_rd;

    // Load-use: the instruction in EX is a load whose result the decoding
    // instruction reads. rt counts as a source only when it is not the
    // destination (muxctrl[0]=0).
    assign hazard = ex_valid_reg && ex_memctrl_reg[2] && (ex_dest_reg != 5'd0) && id_valid &&
                    ((ex_dest_reg == id_rs) || ((ex_dest_reg == id_rt) && !id_muxctrl[0]));
    assign hazard_stall = hazard;

    // Select the update action by priority: flush, stall, hazard, then normal load.
    always_comb begin
        load_bubble  = 1'b0;
        load_instr   = 1'b0;
        count_bubble = 1'b0;
        if (flush) begin
            load_bubble  = 1'b1;
            count_bubble = 1'b1;
        end else if (stall) begin
            load_bubble  = 1'b0;
        end else if (hazard) begin
            load_bubble  = 1'b1;
            count_bubble = 1'b1;
        end else if (!id_valid) begin
            // An empty slot becomes a bubble but is not counted as an inserted one.
            load_bubble  = 1'b1;
        end else begin
            load_instr   = 1'b1;
        end
    end

    always_comb begin
        ex_valid_next   = ex_valid_reg;
        ex_muxctrl_next = ex_muxctrl_reg;
        ex_memctrl_next = ex_memctrl_reg;
        ex_aluctrl_next = ex_aluctrl_reg;
        ex_rd1_next     = ex_rd1_reg;
        ex_rd2_next     = ex_rd2_reg;
        ex_imm_next     = ex_imm_reg;
        ex_pc_next      = ex_pc_reg;
        ex_rs_next      = ex_rs_reg;
        ex_rt_next      = ex_rt_reg;
        ex_shamt_next   = ex_shamt_reg;
        ex_dest_next    = ex_dest_reg;
        if (load_bubble) begin
            ex_valid_next   = 1'b0;
            ex_muxctrl_next = 16'd0;
            ex_memctrl_next = 3'd0;
            ex_aluctrl_next = BUBBLE_ALU;
            ex_rd1_next     = 32'd0;
            ex_rd2_next     = 32'd0;
            ex_imm_next     = 32'd0;
            ex_pc_next      = 32'd0;
            ex_rs_next      = 5'd0;
            ex_rt_next      = 5'd0;
            ex_shamt_next   = 5'd0;
            ex_dest_next    = 5'd0;
        end else if (load_instr) begin
            ex_valid_next   = id_valid;
            ex_muxctrl_next = id_muxctrl;
            ex_memctrl_next = id_memctrl;
            ex_aluctrl_next = id_aluctrl;
            ex_rd1_next     = id_rd1;
            ex_rd2_next     = id_rd2;
            ex_imm_next     = id_imm;
            ex_pc_next      = id_pc;
            ex_rs_next      = id_rs;
            ex_rt_next      = id_rt;
            ex_shamt_next   = id_shamt;
            ex_dest_next    = dest_sel;
        end
    end

    // One increment per edge even if flush and hazard coincide; saturates.
    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        if (count_bubble && (bubble_cnt_reg != CNT_MAX)) begin
            bubble_cnt_next = bubble_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg   <= 1'b0;
            ex_muxctrl_reg <= 16'd0;
            ex_memctrl_reg <= 3'd0;
            ex_aluctrl_reg <= BUBBLE_ALU;
            ex_rd1_reg     <= 32'd0;
            ex_rd2_reg     <= 32'd0;
            ex_imm_reg     <= 32'd0;
            ex_pc_reg      <= 32'd0;
            ex_rs_reg      <= 5'd0;
            ex_rt_reg      <= 5'd0;
            ex_shamt_reg   <= 5'd0;
            ex_dest_reg    <= 5'd0;
            bubble_cnt_reg <= 16'd0;
        end else begin
            ex_valid_reg   <= ex_valid_next;
            ex_muxctrl_reg <= ex_muxctrl_next;
            ex_memctrl_reg <= ex_memctrl_next;
            ex_aluctrl_reg <= ex_aluctrl_next;
            ex_rd1_reg     <= ex_rd1_next;
            ex_rd2_reg     <= ex_rd2_next;
            ex_imm_reg     <= ex_imm_next;
            ex_pc_reg      <= ex_pc_next;
            ex_rs_reg      <= ex_rs_next;
            ex_rt_reg      <= ex_rt_next;
            ex_shamt_reg   <= ex_shamt_next;
            ex_dest_reg    <= ex_dest_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_muxctrl = ex_muxctrl_reg;
    assign ex_memctrl = ex_memctrl_reg;
    assign ex_aluctrl = ex_aluctrl_reg;
    assign ex_rd1     = ex_rd1_reg;
    assign ex_rd2     = ex_rd2_reg;
    assign ex_imm     = ex_imm_reg;
    assign ex_pc      = ex_pc_reg;
    assign ex_rs      = ex_rs_reg;
    assign ex_rt      = ex_rt_reg;
    assign ex_shamt   = ex_shamt_reg;
    assign ex_dest    = ex_dest_reg;
    assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage: a table of single-cycle vectors with
// hand-computed expectations, plus hand-written sequences for full-field
// capture, reset behaviour and counter saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [15:0] id_muxctrl;
    logic [2:0]  id_memctrl;
    logic [4:0]  id_aluctrl;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic        stall, flush;
    logic        ex_valid;
    logic [15:0] ex_muxctrl;
    logic [2:0]  ex_memctrl;
    logic [4:0]  ex_aluctrl;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
    logic [4:0]  ex_rs, ex_rt, ex_shamt, ex_dest;
    logic        hazard_stall;
    logic [15:0] bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_muxctrl(id_muxctrl), .id_memctrl(id_memctrl),
        .id_aluctrl(id_aluctrl), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_muxctrl(ex_muxctrl), .ex_memctrl(ex_memctrl),
        .ex_aluctrl(ex_aluctrl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_shamt(ex_shamt),
        .ex_dest(ex_dest), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] mux;
        logic [2:0]  mem;
        logic [4:0]  alu;
        logic [31:0] rd1;
        logic [4:0]  rs, rt, rd;
        logic        stl, fl;
        logic        e_hz;
        logic        e_valid;
        logic [4:0]  e_dest;
        logic [4:0]  e_alu;
        logic [2:0]  e_mem;
        logic [31:0] e_rd1;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic v, logic [15:0] mux, logic [2:0] mem, logic [4:0] alu,
                                logic [31:0] rd1, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic stl, logic fl, logic e_hz, logic e_valid, logic [4:0] e_dest,
                                logic [4:0] e_alu, logic [2:0] e_mem, logic [31:0] e_rd1,
                                logic [15:0] e_cnt);
        vec_t r;
        r.valid = v; r.mux = mux; r.mem = mem; r.alu = alu; r.rd1 = rd1;
        r.rs = rs; r.rt = rt; r.rd = rd; r.stl = stl; r.fl = fl;
        r.e_hz = e_hz; r.e_valid = e_valid; r.e_dest = e_dest; r.e_alu = e_alu;
        r.e_mem = e_mem; r.e_rd1 = e_rd1; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] mux, input logic [2:0] mem,
                         input logic [4:0] alu, input logic [31:0] rd1, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic stl,
                         input logic fl);
        id_valid = v; id_muxctrl = mux; id_memctrl = mem; id_aluctrl = alu;
        id_rd1 = rd1; id_rd2 = rd1 ^ 32'hFFFF_0000; id_imm = rd1 + 32'd2; id_pc = rd1 + 32'd4;
        id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = 5'd0;
        stall = stl; flush = fl;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, " valid"},  {31'd0, ex_valid}, 32'd0);
        check({tag, " mux"},    {16'd0, ex_muxctrl}, 32'd0);
        check({tag, " mem"},    {29'd0, ex_memctrl}, 32'd0);
        check({tag, " alu"},    {27'd0, ex_aluctrl}, 32'd13);
        check({tag, " rd1"},    ex_rd1, 32'd0);
        check({tag, " rd2"},    ex_rd2, 32'd0);
        check({tag, " imm"},    ex_imm, 32'd0);
        check({tag, " pc"},     ex_pc, 32'd0);
        check({tag, " rs"},     {27'd0, ex_rs}, 32'd0);
        check({tag, " rt"},     {27'd0, ex_rt}, 32'd0);
        check({tag, " shamt"},  {27'd0, ex_shamt}, 32'd0);
        check({tag, " dest"},   {27'd0, ex_dest}, 32'd0);
    endtask

    initial begin
        // v  mux  mem  alu  rd1  rs rt rd stl fl | hz ev dest alu mem rd1 cnt
        vecs[0]  = mk(1, 16'h0, 3'b001, 5'd2, 32'h10, 1, 2, 5,  0, 0, 0, 1, 5,  2,  3'b001, 32'h10, 0);
        vecs[1]  = mk(1, 16'h1, 3'b100, 5'd0, 32'h20, 3, 8, 0,  0, 0, 0, 1, 8,  0,  3'b100, 32'h20, 0);
        vecs[2]  = mk(1, 16'h0, 3'b001, 5'd2, 32'h30, 8, 2, 9,  0, 0, 1, 0, 0,  13, 3'b000, 32'h0,  1);
        vecs[3]  = mk(1, 16'h0, 3'b001, 5'd2, 32'h30, 8, 2, 9,  0, 0, 0, 1, 9,  2,  3'b001, 32'h30, 1);
        vecs[4]  = mk(1, 16'h1, 3'b100, 5'd0, 32'h40, 3, 0, 0,  0, 0, 0, 1, 0,  0,  3'b100, 32'h40, 1);
        vecs[5]  = mk(1, 16'h0, 3'b001, 5'd2, 32'h50, 0, 0, 6,  0, 0, 0, 1, 6,  2,  3'b001, 32'h50, 1);
        vecs[6]  = mk(1, 16'h1, 3'b100, 5'd0, 32'h60, 3, 8, 0,  0, 0, 0, 1, 8,  0,  3'b100, 32'h60, 1);
        vecs[7]  = mk(1, 16'h1, 3'b001, 5'd3, 32'h70, 3, 8, 0,  0, 0, 0, 1, 8,  3,  3'b001, 32'h70, 1);
        vecs[8]  = mk(1, 16'h1, 3'b100, 5'd0, 32'h80, 3, 8, 0,  0, 0, 0, 1, 8,  0,  3'b100, 32'h80, 1);
        vecs[9]  = mk(1, 16'h0, 3'b001, 5'd2, 32'h90, 1, 8, 10, 0, 0, 1, 0, 0,  13, 3'b000, 32'h0,  2);
        vecs[10] = mk(1, 16'h0, 3'b001, 5'd2, 32'h90, 1, 8, 10, 0, 1, 0, 0, 0,  13, 3'b000, 32'h0,  3);
        vecs[11] = mk(0, 16'h5, 3'b111, 5'd7, 32'h99, 4, 5, 6,  0, 0, 0, 0, 0,  13, 3'b000, 32'h0,  3);
        vecs[12] = mk(1, 16'h0, 3'b001, 5'd2, 32'hA0, 1, 2, 11, 0, 0, 0, 1, 11, 2,  3'b001, 32'hA0, 3);
        vecs[13] = mk(1, 16'h1, 3'b100, 5'd0, 32'hB0, 3, 4, 0,  1, 0, 0, 1, 11, 2,  3'b001, 32'hA0, 3);
        vecs[14] = mk(1, 16'h0, 3'b001, 5'd4, 32'hC0, 5, 6, 7,  1, 0, 0, 1, 11, 2,  3'b001, 32'hA0, 3);
        vecs[15] = mk(0, 16'h0, 3'b000, 5'd0, 32'hD0, 0, 0, 0,  1, 0, 0, 1, 11, 2,  3'b001, 32'hA0, 3);
        vecs[16] = mk(1, 16'h0, 3'b001, 5'd2, 32'hD8, 1, 2, 3,  1, 1, 0, 0, 0,  13, 3'b000, 32'h0,  4);
        vecs[17] = mk(1, 16'h1, 3'b100, 5'd0, 32'hE0, 3, 8, 0,  0, 0, 0, 1, 8,  0,  3'b100, 32'hE0, 4);
        vecs[18] = mk(1, 16'h0, 3'b001, 5'd2, 32'hE8, 8, 2, 9,  0, 1, 1, 0, 0,  13, 3'b000, 32'h0,  5);
        vecs[19] = mk(1, 16'h1, 3'b100, 5'd0, 32'hF0, 3, 7, 0,  0, 0, 0, 1, 7,  0,  3'b100, 32'hF0, 5);
        vecs[20] = mk(1, 16'h0, 3'b001, 5'd2, 32'h111,7, 2, 12, 1, 0, 1, 1, 7,  0,  3'b100, 32'hF0, 5);
        vecs[21] = mk(1, 16'h0, 3'b001, 5'd2, 32'h111,7, 2, 12, 0, 0, 1, 0, 0,  13, 3'b000, 32'h0,  6);
        vecs[22] = mk(1, 16'h0, 3'b001, 5'd2, 32'h111,7, 2, 12, 0, 0, 0, 1, 12, 2,  3'b001, 32'h111,6);

        // Reset with flush and stall also high: reset wins.
        reset = 1'b1;
        drive(1, 16'h0, 3'b001, 5'd2, 32'h55, 1, 2, 3, 1, 1);
        step();
        step();
        check_bubble("reset");
        check("reset cnt", {16'd0, bubble_cnt}, 32'd0);
        check("reset hz", {31'd0, hazard_stall}, 32'd0);
        reset = 1'b0;

        // Full-field capture of a normal load; dest taken from rt when muxctrl[0]=1.
        drive(1, 16'hA5A1, 3'b010, 5'd6, 32'h1234_5678, 5'd3, 5'd4, 5'd9, 0, 0);
        id_shamt = 5'd17;
        step();
        $display("capture: valid=%0d dest=%0d rd1=%h", ex_valid, ex_dest, ex_rd1);
        check("cap valid", {31'd0, ex_valid}, 32'd1);
        check("cap mux",   {16'd0, ex_muxctrl}, 32'h0000_A5A1);
        check("cap mem",   {29'd0, ex_memctrl}, 32'd2);
        check("cap alu",   {27'd0, ex_aluctrl}, 32'd6);
        check("cap rd1",   ex_rd1, 32'h1234_5678);
        check("cap rd2",   ex_rd2, 32'hEDCB_5678);
        check("cap imm",   ex_imm, 32'h1234_567A);
        check("cap pc",    ex_pc,  32'h1234_567C);
        check("cap rs",    {27'd0, ex_rs}, 32'd3);
        check("cap rt",    {27'd0, ex_rt}, 32'd4);
        check("cap shamt", {27'd0, ex_shamt}, 32'd17);
        check("cap dest",  {27'd0, ex_dest}, 32'd4);

        // Table of single-cycle vectors.
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].valid, vecs[i].mux, vecs[i].mem, vecs[i].alu, vecs[i].rd1,
                  vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].stl, vecs[i].fl);
            #1;
            check($sformatf("v%0d hz", i), {31'd0, hazard_stall}, {31'd0, vecs[i].e_hz});
            step();
            $display("vec %0d: stall=%0d flush=%0d -> valid=%0d dest=%0d alu=%0d mem=%0d rd1=%h cnt=%0d",
                     i, vecs[i].stl, vecs[i].fl, ex_valid, ex_dest, ex_aluctrl, ex_memctrl, ex_rd1,
                     bubble_cnt);
            check($sformatf("v%0d valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("v%0d dest", i), {27'd0, ex_dest}, {27'd0, vecs[i].e_dest});
            check($sformatf("v%0d alu", i), {27'd0, ex_aluctrl}, {27'd0, vecs[i].e_alu});
            check($sformatf("v%0d mem", i), {29'd0, ex_memctrl}, {29'd0, vecs[i].e_mem});
            check($sformatf("v%0d rd1", i), ex_rd1, vecs[i].e_rd1);
            check($sformatf("v%0d cnt", i), {16'd0, bubble_cnt}, {16'd0, vecs[i].e_cnt});
        end

        // Reset mid-stream with a valid SW in the stage.
        drive(1, 16'h0, 3'b010, 5'd2, 32'h200, 1, 2, 0, 0, 0);
        step();
        check("sw valid", {31'd0, ex_valid}, 32'd1);
        check("sw mem", {29'd0, ex_memctrl}, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("mid reset: valid=%0d mem=%0d alu=%0d cnt=%0d", ex_valid, ex_memctrl, ex_aluctrl, bubble_cnt);
        check_bubble("midrst");
        check("midrst cnt", {16'd0, bubble_cnt}, 32'd0);
        // A would-be dependent instruction must not flag a hazard after reset.
        drive(1, 16'h0, 3'b001, 5'd2, 32'h0, 0, 0, 1, 0, 0);
        #1;
        check("midrst hz", {31'd0, hazard_stall}, 32'd0);

        // Saturation: 65534 flushes reach FFFE, three more stay at FFFF.
        drive(0, 16'h0, 3'b000, 5'd0, 32'h0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 65534; i++) begin
            step();
        end
        $display("after 65534 flushes: cnt=%h", bubble_cnt);
        check("sat pre", {16'd0, bubble_cnt}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            $display("sat flush %0d: cnt=%h", i, bubble_cnt);
            check($sformatf("sat %0d", i), {16'd0, bubble_cnt}, 32'h0000_FFFF);
        end
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
